// File: rtl/carry_lookahead_adder4_pkg.sv
// Shared constants and types for the 4-bit carry-lookahead adder slice.
// Provides the slice width and the operand vector type.
package carry_lookahead_adder4_pkg;

   localparam int CLA_WIDTH = 4;

   typedef logic [CLA_WIDTH-1:0] cla_vec_t;

endpackage

// File: rtl/carry_lookahead_unit4.sv
// Flat two-level carry-lookahead unit over four bit (or group) positions.
// Ports: p, g (4-bit propagate/generate), c0 (carry-in) -> c[3:1], grp_g, grp_p.
module carry_lookahead_unit4
   import carry_lookahead_adder4_pkg::*;
(
   input  logic [CLA_WIDTH-1:0] p,
   input  logic [CLA_WIDTH-1:0] g,
   input  logic                 c0,
   output logic [3:1]           c,
   output logic                 grp_g,
   output logic                 grp_p
);

   // Every carry is a sum of products of g/p/c0; no carry depends on another.
   always_comb begin
      c[1] = g[0]
           | (p[0] & c0);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & c0);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
   end

   // Group terms exclude c0 so a parent unit can combine slices in parallel.
   always_comb begin
      grp_g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
   end

endmodule

// File: rtl/carry_lookahead_adder4.sv
// 4-bit carry-lookahead adder slice with registered sum and group G/P.
// Ports: Clock, ResetN (async low), InputA, InputB, InputCarry -> Output, GroupGeneration, GroupPropagation.
module carry_lookahead_adder4
   import carry_lookahead_adder4_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
)(
   input  logic             Clock,
   input  logic             ResetN,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic             InputCarry,
   output logic [WIDTH-1:0] Output,
   output logic             GroupGeneration,
   output logic             GroupPropagation
);

   if (WIDTH != CLA_WIDTH) begin : g_bad_width
      $error("carry_lookahead_adder4: WIDTH must be 4");
   end

   cla_vec_t   bit_g;
   cla_vec_t   bit_p;
   cla_vec_t   carry;
   cla_vec_t   sum;
   logic [3:1] carry_hi;
   logic       grp_g;
   logic       grp_p;

   // XOR propagate doubles as the half-sum and keeps G and P exclusive.
   assign bit_g = InputA & InputB;
   assign bit_p = InputA ^ InputB;

   carry_lookahead_unit4 u_lookahead (
      .p     (bit_p),
      .g     (bit_g),
      .c0    (InputCarry),
      .c     (carry_hi),
      .grp_g (grp_g),
      .grp_p (grp_p)
   );

   assign carry = {carry_hi, InputCarry};
   assign sum   = bit_p ^ carry;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         Output           <= '0;
         GroupGeneration  <= 1'b0;
         GroupPropagation <= 1'b0;
      end else begin
         Output           <= sum;
         GroupGeneration  <= grp_g;
         GroupPropagation <= grp_p;
      end
   end

endmodule

// File: tb/tb_carry_lookahead_adder4.sv
// Self-checking bench for carry_lookahead_adder4.
// Directed, exhaustive and random vectors against an arithmetic reference.
module tb_carry_lookahead_adder4;

   logic       Clock;
   logic       ResetN;
   logic [3:0] InputA;
   logic [3:0] InputB;
   logic       InputCarry;
   logic [3:0] Output;
   logic       GroupGeneration;
   logic       GroupPropagation;

   int checks = 0;
   int errors = 0;

   carry_lookahead_adder4 dut (
      .Clock            (Clock),
      .ResetN           (ResetN),
      .InputA           (InputA),
      .InputB           (InputB),
      .InputCarry       (InputCarry),
      .Output           (Output),
      .GroupGeneration  (GroupGeneration),
      .GroupPropagation (GroupPropagation)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference: plain integer addition. G is "carries out with Cin=0",
   // P is "carries out exactly when Cin=1" (operand sum is 15).
   function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, output logic [3:0] s,
                                 output logic g, output logic p);
      int total;
      int ab;
      ab    = int'(a) + int'(b);
      total = ab + int'(cin);
      s     = 4'(total % 16);
      g     = (ab > 15);
      p     = (ab == 15);
   endfunction

   task automatic check(input string tag, input logic [3:0] es,
                        input logic eg, input logic ep);
      checks++;
      assert (Output === es) else begin
         errors++;
         $error("FAIL %s Output observed=%h expected=%h", tag, Output, es);
      end
      checks++;
      assert (GroupGeneration === eg) else begin
         errors++;
         $error("FAIL %s G observed=%b expected=%b", tag, GroupGeneration, eg);
      end
      checks++;
      assert (GroupPropagation === ep) else begin
         errors++;
         $error("FAIL %s P observed=%b expected=%b", tag, GroupPropagation, ep);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b,
                        input logic cin);
      InputA     = a;
      InputB     = b;
      InputCarry = cin;
   endtask

   // Drive one vector, let one edge capture it, check just after the edge.
   task automatic apply(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic cin);
      logic [3:0] s;
      logic       g;
      logic       p;
      drive(a, b, cin);
      model(a, b, cin, s, g, p);
      @(posedge Clock);
      #1;
      check(tag, s, g, p);
   endtask

   logic [3:0] prev_s;
   logic       prev_g;
   logic       prev_p;
   logic [3:0] ra;
   logic [3:0] rb;
   logic       rc;
   logic [3:0] ms;
   logic       mg;
   logic       mp;

   initial begin
      // Reset is asynchronous: outputs clear before any clock edge.
      ResetN = 1'b0;
      drive(4'hF, 4'hF, 1'b1);
      #1;
      check("reset_async", 4'h0, 1'b0, 1'b0);

      @(negedge Clock);
      ResetN = 1'b1;
      @(posedge Clock);
      #1;
      check("reset_first", 4'hF, 1'b1, 1'b0);

      // Zero / identity.
      apply("zero",   4'h0, 4'h0, 1'b0);
      check("zero_k", 4'h0, 1'b0, 1'b0);
      apply("one_a",  4'h1, 4'h0, 1'b0);
      check("one_a_k", 4'h1, 1'b0, 1'b0);
      apply("cin",    4'h0, 4'h0, 1'b1);
      check("cin_k",  4'h1, 1'b0, 1'b0);

      // Overflow.
      apply("ovf_ff1", 4'hF, 4'hF, 1'b1);
      check("ovf_ff1_k", 4'hF, 1'b1, 1'b0);
      apply("ovf_ef1", 4'hE, 4'hF, 1'b1);
      check("ovf_ef1_k", 4'hE, 1'b1, 1'b0);
      apply("ovf_fe1", 4'hF, 4'hE, 1'b1);
      check("ovf_fe1_k", 4'hE, 1'b1, 1'b0);
      apply("ovf_ff0", 4'hF, 4'hF, 1'b0);
      check("ovf_ff0_k", 4'hE, 1'b1, 1'b0);

      // Full propagate.
      apply("prop_a50", 4'hA, 4'h5, 1'b0);
      check("prop_a50_k", 4'hF, 1'b0, 1'b1);
      apply("prop_5a0", 4'h5, 4'hA, 1'b0);
      check("prop_5a0_k", 4'hF, 1'b0, 1'b1);
      apply("prop_a51", 4'hA, 4'h5, 1'b1);
      check("prop_a51_k", 4'h0, 1'b0, 1'b1);
      apply("prop_5a1", 4'h5, 4'hA, 1'b1);
      check("prop_5a1_k", 4'h0, 1'b0, 1'b1);

      // Back-to-back: output holds the previous result until the next edge.
      prev_s = 4'h0;
      prev_g = 1'b0;
      prev_p = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rc = 1'($urandom_range(0, 1));
         drive(ra, rb, rc);
         #2;
         check("latency_hold", prev_s, prev_g, prev_p);
         model(ra, rb, rc, ms, mg, mp);
         @(posedge Clock);
         #1;
         check("latency_next", ms, mg, mp);
         prev_s = ms;
         prev_g = mg;
         prev_p = mp;
      end

      // Reset mid-operation discards the in-flight result.
      apply("pre_rst", 4'h7, 4'h3, 1'b1);
      drive(4'h9, 4'h9, 1'b1);
      #2;
      ResetN = 1'b0;
      #1;
      check("mid_reset", 4'h0, 1'b0, 1'b0);
      @(posedge Clock);
      #1;
      check("mid_reset_hold", 4'h0, 1'b0, 1'b0);
      @(negedge Clock);
      ResetN = 1'b1;
      apply("post_rst", 4'h9, 4'h9, 1'b1);

      // Exhaustive sweep with arithmetic identities.
      for (int v = 0; v < 512; v++) begin
         ra = 4'(v % 16);
         rb = 4'((v / 16) % 16);
         rc = 1'(v / 256);
         apply("exh", ra, rb, rc);
         checks++;
         assert ({GroupGeneration | (GroupPropagation & rc), Output}
                 === 5'(int'(ra) + int'(rb) + int'(rc))) else begin
            errors++;
            $error("FAIL exh_cout observed=%b%h expected=%0d",
                   GroupGeneration | (GroupPropagation & rc), Output,
                   int'(ra) + int'(rb) + int'(rc));
         end
         checks++;
         assert ((GroupGeneration & GroupPropagation) === 1'b0) else begin
            errors++;
            $error("FAIL exh_gp_excl observed=%b expected=0",
                   GroupGeneration & GroupPropagation);
         end
      end

      // Random vectors.
      for (int i = 0; i < 200; i++) begin
         apply("rand", 4'($urandom), 4'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
